// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode constants and GCD controller state encoding
package alu_pkg;

  // Opcodes understood by the external 32-bit ALU
  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_GT   = 3'd5;
  localparam logic [2:0] ALU_EQ   = 3'd6;
  localparam logic [2:0] ALU_SHL  = 3'd7;

  // Controller states: one compare-equal, one compare-greater, one subtract per step
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EQ   = 3'd1,
    GT   = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/alu_gcd_ctrl_if.sv
// rtl/alu_gcd_ctrl_if.sv - request/result and external ALU signals of the GCD controller
interface alu_gcd_ctrl_if;

  logic        start;
  logic [31:0] Op_A;
  logic [31:0] Op_B;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] Result;
  logic [2:0]  Upr_ALU;
  logic [31:0] A_ALU;
  logic [31:0] B_ALU;
  logic        C_ALU;
  logic [31:0] Out_ALU;

  // Requester plus ALU side
  modport master (
    output start, Op_A, Op_B, C_ALU, Out_ALU,
    input  busy, done, err, Result, Upr_ALU, A_ALU, B_ALU
  );

  // Controller side
  modport slave (
    input  start, Op_A, Op_B, C_ALU, Out_ALU,
    output busy, done, err, Result, Upr_ALU, A_ALU, B_ALU
  );

endinterface

// File: rtl/alu_gcd_ctrl.sv
// rtl/alu_gcd_ctrl.sv - GCD by repeated subtraction, sequencing an external ALU
module alu_gcd_ctrl
  import alu_pkg::*;
#(
  parameter logic [31:0] ITER_LIMIT = 32'd1024
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_gcd_ctrl_if.slave bus
);

  state_t      state_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [31:0] n_q;
  logic        gt_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] result_q;
  logic [2:0]  upr_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] n_inc;

  assign n_inc = n_q + 32'd1;

  // ALU drive is registered one state ahead so it is stable for the whole state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      n_q      <= '0;
      gt_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      upr_q    <= ALU_ZERO;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q   <= bus.Op_A;
            y_q   <= bus.Op_B;
            n_q   <= '0;
            err_q <= 1'b0;
            if (bus.Op_A == 32'd0) begin
              result_q <= bus.Op_B;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else if (bus.Op_B == 32'd0) begin
              result_q <= bus.Op_A;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              busy_q  <= 1'b1;
              upr_q   <= ALU_EQ;
              a_q     <= bus.Op_A;
              b_q     <= bus.Op_B;
              state_q <= EQ;
            end
          end
        end
        EQ: begin
          if (bus.C_ALU) begin
            result_q <= x_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            upr_q    <= ALU_ZERO;
            a_q      <= '0;
            b_q      <= '0;
            state_q  <= DONE;
          end else begin
            upr_q   <= ALU_GT;
            state_q <= GT;
          end
        end
        GT: begin
          // Larger operand becomes the minuend so the difference never wraps
          gt_q    <= bus.C_ALU;
          upr_q   <= ALU_SUB;
          a_q     <= bus.C_ALU ? x_q : y_q;
          b_q     <= bus.C_ALU ? y_q : x_q;
          state_q <= SUB;
        end
        SUB: begin
          n_q <= n_inc;
          if (gt_q) x_q <= bus.Out_ALU;
          else      y_q <= bus.Out_ALU;
          if (n_inc == ITER_LIMIT) begin
            result_q <= '0;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            upr_q    <= ALU_ZERO;
            a_q      <= '0;
            b_q      <= '0;
            state_q  <= DONE;
          end else begin
            upr_q   <= ALU_EQ;
            a_q     <= gt_q ? bus.Out_ALU : x_q;
            b_q     <= gt_q ? y_q : bus.Out_ALU;
            state_q <= EQ;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          upr_q   <= ALU_ZERO;
          a_q     <= '0;
          b_q     <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.Result  = result_q;
  assign bus.Upr_ALU = upr_q;
  assign bus.A_ALU   = a_q;
  assign bus.B_ALU   = b_q;

endmodule

// File: doc/alu_gcd_ctrl.md
ALU_GCD_CTRL -- requirements
Module: alu_gcd_ctrl

Interface
REQ-001 Parameter ITER_LIMIT, 1024, maximum number of subtract steps before abort; legal range 1..2^32-1.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 Op_A  input  32  first unsigned operand, sampled with start.
REQ-006 Op_B  input  32  second unsigned operand, sampled with start.
REQ-007 busy  output  1  high in states EQ, GT, SUB.
REQ-008 done  output  1  one-cycle pulse, high only in state DONE.
REQ-009 err  output  1  iteration limit hit; valid with done, held until next accepted start.
REQ-010 Result  output  32  GCD; valid with done, held until next accepted start.
REQ-011 Upr_ALU  output  3  operation code driven to the external ALU.
REQ-012 A_ALU  output  32  ALU operand A.
REQ-013 B_ALU  output  32  ALU operand B.
REQ-014 C_ALU  input  1  ALU flag (unsigned A>B for code 5, A==B for code 6), combinational, same cycle.
REQ-015 Out_ALU  input  32  ALU result, combinational, same cycle.

Function
REQ-016 The block SHALL compute unsigned GCD(Op_A, Op_B) by repeated subtraction using only ALU codes 6 (EQ), 5 (GT) and 2 (SUB).
REQ-017 States SHALL be IDLE, EQ, GT, SUB, DONE.
REQ-018 IDLE: on start, latch x=Op_A, y=Op_B, clear err and iteration counter n; if Op_A==0 go DONE with Result=Op_B; else if Op_B==0 go DONE with Result=Op_A; else go EQ.
REQ-019 EQ: drive Upr_ALU=6, A_ALU=x, B_ALU=y; C_ALU=1 -> Result=x, go DONE; else go GT.
REQ-020 GT: drive Upr_ALU=5, A_ALU=x, B_ALU=y; register C_ALU as flag gt; go SUB.
REQ-021 SUB: gt=1 -> Upr_ALU=2, A_ALU=x, B_ALU=y, x<=Out_ALU; gt=0 -> A_ALU=y, B_ALU=x, y<=Out_ALU; n<=n+1; if n+1==ITER_LIMIT go DONE with Result=0, err=1; else go EQ.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-023 In IDLE and DONE, Upr_ALU=0 and A_ALU=B_ALU=0.
REQ-024 start outside IDLE (including in DONE) SHALL be ignored.
REQ-025 Latency, start accepted at edge 0: zero operand -> done in cycle 1; otherwise done in cycle 2+3*k, k = subtract steps; abort -> done in cycle 1+3*ITER_LIMIT.
REQ-026 Subtraction never underflows: minuend always the larger operand; x,y stay nonzero.

Reset
REQ-027 rst_n low at a clock edge SHALL force IDLE, busy=0, done=0, err=0, Result=0, Upr_ALU=0, A_ALU=B_ALU=0, x=y=n=0, gt=0, including mid-operation.
REQ-028 start coincident with rst_n low SHALL be discarded.

Structure
REQ-029 Package alu_pkg SHALL hold the ALU opcode constants (ZERO=0, ADD=1, SUB=2, AND=3, OR=4, GT=5, EQ=6, SHL=7) and the state enum.
REQ-030 No sub-module inside alu_gcd_ctrl; the ALU stays external and the bench connects the team's 32-bit ALU.

Verification
REQ-031 start, Op_A=12, Op_B=8 -> done in cycle 8, Result=4, err=0; Upr_ALU sequence 6,5,2,6,5,2,6.
REQ-032 start, Op_A=7, Op_B=7 -> done in cycle 2, Result=7, busy high only in cycle 1.
REQ-033 start, Op_A=0, Op_B=5 -> done in cycle 1, Result=5; Op_A=0, Op_B=0 -> Result=0, err=0.
REQ-034 ITER_LIMIT=4, Op_A=100, Op_B=1 -> done in cycle 13, err=1, Result=0.
REQ-035 Op_A=12, Op_B=8, rst_n low in cycle 4 -> IDLE next cycle, all outputs zero, no done; subsequent start with Op_A=9, Op_B=6 -> Result=3 in cycle 8.
REQ-036 start held high through a whole run -> start during busy and DONE ignored; new run begins only from IDLE, done pulses exactly once per accepted start.
